// File: rtl/boracore_pkg.sv
// boracore_pkg: shared definitions for the parametrised boracore CPU.
//   - opcode encodings
//   - FSM state encoding
//   - instruction field slicers; instruction word is {op[3:0], rd, rs, imm}
//     where rd/rs are RSEL_W bits and imm is DATA_W bits.
// The slicers take the widths as arguments so one set of functions serves
// every parameterisation; callers zero-extend the word to field_t and
// truncate the result back to the field width.
package boracore_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JNZ  = 4'hA;
    localparam logic [3:0] OP_ADDI = 4'hB;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Widest instruction word the slicers accept.
    localparam int FIELD_MAX_W = 64;
    typedef logic [FIELD_MAX_W-1:0] field_t;

    function automatic field_t low_mask(input int w);
        return (field_t'(1) << w) - field_t'(1);
    endfunction

    function automatic logic [3:0] instr_op(input field_t w, input int rsel_w, input int data_w);
        field_t t;
        t = w >> (2 * rsel_w + data_w);
        return t[3:0];
    endfunction

    function automatic field_t instr_rd(input field_t w, input int rsel_w, input int data_w);
        return (w >> (rsel_w + data_w)) & low_mask(rsel_w);
    endfunction

    function automatic field_t instr_rs(input field_t w, input int rsel_w, input int data_w);
        return (w >> data_w) & low_mask(rsel_w);
    endfunction

    function automatic field_t instr_imm(input field_t w, input int data_w);
        return w & low_mask(data_w);
    endfunction

endpackage

// File: rtl/boracore_alu.sv
// boracore_alu: combinational ALU for the boracore CPU.
// Ports:
//   op     - opcode; ADD/ADDI, SUB, AND, OR, XOR are computed, anything else
//            passes b through with c=0
//   a, b   - operands (a = rd, b = rs or imm)
//   result - a op b, mod 2**DATA_W
//   z      - result == 0
//   c      - carry-out for ADD/ADDI, borrow (a<b) for SUB, 0 otherwise
module boracore_alu
    import boracore_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = b;
        c      = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
            end
            OP_SUB: begin
                result = a - b;
                c      = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: ;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/boracore_cpu_p.sv
// boracore_cpu_p: parametrised multi-cycle CPU (FETCH -> EXEC, or HALT).
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   imem_addr   - fetch address (always equals ip)
//   imem_data   - instruction word {op, rd, rs, imm}, sampled in FETCH only
//   imem_valid  - imem_data valid; FETCH stalls while low
//   dbg_sel     - register index for debug read
//   dbg_reg     - combinational read of reg[dbg_sel]
//   ip          - instruction pointer
//   flag_z/c    - zero and carry/borrow flags
//   halted      - high once HLT has executed, until reset
module boracore_cpu_p
    import boracore_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int NREG    = 4,
    parameter int RSEL_W  = $clog2(NREG),
    parameter int INSTR_W = 4 + 2 * RSEL_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    input  logic [RSEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_reg,
    output logic [ADDR_W-1:0]  ip,
    output logic               flag_z,
    output logic               flag_c,
    output logic               halted
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ip_q, ip_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                z_q, z_d, c_q, c_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];

    // Decode of the held instruction register
    field_t              ir_w;
    logic [3:0]          op;
    logic [RSEL_W-1:0]   rd, rs;
    logic [DATA_W-1:0]   imm;

    assign ir_w = field_t'(ir_q);
    assign op   = instr_op(ir_w, RSEL_W, DATA_W);
    assign rd   = RSEL_W'(instr_rd(ir_w, RSEL_W, DATA_W));
    assign rs   = RSEL_W'(instr_rs(ir_w, RSEL_W, DATA_W));
    assign imm  = DATA_W'(instr_imm(ir_w, DATA_W));

    logic [DATA_W-1:0]   alu_b, alu_res;
    logic                alu_z, alu_c;
    logic [ADDR_W-1:0]   ip_inc, jtgt;

    assign alu_b  = (op == OP_ADDI) ? imm : regs_q[rs];
    assign ip_inc = ip_q + ADDR_W'(1);   // wraps naturally at 2**ADDR_W
    assign jtgt   = ADDR_W'(imm);        // truncate or zero-extend

    boracore_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (regs_q[rd]),
        .b      (alu_b),
        .result (alu_res),
        .z      (alu_z),
        .c      (alu_c)
    );

    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        ir_d    = ir_q;
        z_d     = z_q;
        c_d     = c_q;
        regs_d  = regs_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                ip_d    = ip_inc;
                case (op)
                    OP_LDI: regs_d[rd] = imm;
                    OP_MOV: regs_d[rd] = regs_q[rs];
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                        regs_d[rd] = alu_res;
                        z_d        = alu_z;
                        c_d        = alu_c;
                    end
                    OP_JMP: ip_d = jtgt;
                    OP_JZ:  if (z_q)  ip_d = jtgt;
                    OP_JNZ: if (!z_q) ip_d = jtgt;
                    OP_HLT: begin
                        state_d = ST_HALT;
                        ip_d    = ip_q;   // HLT keeps ip at its own address
                    end
                    default: ;            // NOP and unused opcodes
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ip_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
            regs_q  <= regs_d;
        end
    end

    assign imem_addr = ip_q;
    assign ip        = ip_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign halted    = (state_q == ST_HALT);
    assign dbg_reg   = regs_q[dbg_sel];

endmodule

// File: tb/tb_boracore_cpu_p.sv
// Bench for boracore_cpu_p: a default instance (ADDR_W=8) and an ADDR_W=4
// instance run the same stimulus. Each cycle the driver advances an
// instruction-level reference model for each instance and queues the
// expected post-edge architectural state; a monitor pops and compares.
module tb_boracore_cpu_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        imem_valid = 1'b0;
    logic [1:0]  dbg_sel = 2'd0;

    logic [15:0] prog [256];

    logic [7:0]  a_addr, a_ip, a_dbg;
    logic [15:0] a_data;
    logic        a_z, a_c, a_h;
    logic [3:0]  b_addr, b_ip;
    logic [7:0]  b_dbg;
    logic [15:0] b_data;
    logic        b_z, b_c, b_h;

    assign a_data = prog[a_addr];
    assign b_data = prog[{4'h0, b_addr}];

    boracore_cpu_p dut_a (
        .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_data(a_data),
        .imem_valid(imem_valid), .dbg_sel(dbg_sel), .dbg_reg(a_dbg),
        .ip(a_ip), .flag_z(a_z), .flag_c(a_c), .halted(a_h)
    );

    boracore_cpu_p #(.ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_data(b_data),
        .imem_valid(imem_valid), .dbg_sel(dbg_sel), .dbg_reg(b_dbg),
        .ip(b_ip), .flag_z(b_z), .flag_c(b_c), .halted(b_h)
    );

    // Reference model: architectural state plus phase (0 fetch, 1 exec, 2 halted)
    typedef struct packed {
        logic [3:0][7:0] r;
        logic [7:0]      ip;
        logic            z, c;
        logic [1:0]      ph;
        logic [15:0]     ir;
    } mst_t;

    typedef struct packed {
        logic [7:0] ip;
        logic       z, c, h;
        logic [7:0] dbg;
    } exp_t;

    mst_t ma, mb;
    exp_t qa[$], qb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic mst_t step(mst_t s, int aw, bit r, bit v, logic [15:0] w);
        mst_t n;
        int op, rd, rs, imm, a, b, t, lim;
        n = s;
        lim = 1 << aw;
        if (r) begin
            n = '0;
            return n;
        end
        if (s.ph == 2'd0) begin
            if (v) begin
                n.ir = w;
                n.ph = 2'd1;
            end
        end else if (s.ph == 2'd1) begin
            op  = int'(s.ir[15:12]);
            rd  = int'(s.ir[11:10]);
            rs  = int'(s.ir[9:8]);
            imm = int'(s.ir[7:0]);
            a   = int'(s.r[rd]);
            b   = int'(s.r[rs]);
            n.ph = 2'd0;
            n.ip = 8'((int'(s.ip) + 1) % lim);
            case (op)
                1: n.r[rd] = 8'(imm);
                2: n.r[rd] = 8'(b);
                3, 11: begin
                    t = a + ((op == 11) ? imm : b);
                    n.r[rd] = 8'(t % 256);
                    n.c = (t > 255);
                    n.z = ((t % 256) == 0);
                end
                4: begin
                    t = (a - b + 256) % 256;
                    n.r[rd] = 8'(t);
                    n.c = (a < b);
                    n.z = (t == 0);
                end
                5, 6, 7: begin
                    t = (op == 5) ? (a & b) : (op == 6) ? (a | b) : (a ^ b);
                    n.r[rd] = 8'(t);
                    n.c = 1'b0;
                    n.z = (t == 0);
                end
                8:  n.ip = 8'(imm % lim);
                9:  if (s.z)  n.ip = 8'(imm % lim);
                10: if (!s.z) n.ip = 8'(imm % lim);
                15: begin
                    n.ph = 2'd2;
                    n.ip = s.ip;
                end
                default: ;
            endcase
        end
        return n;
    endfunction

    function automatic exp_t expect_of(mst_t s, logic [1:0] sel);
        exp_t e;
        e.ip  = s.ip;
        e.z   = s.z;
        e.c   = s.c;
        e.h   = (s.ph == 2'd2);
        e.dbg = s.r[sel];
        return e;
    endfunction

    function automatic logic [15:0] ins(int op, int rd, int rs, int imm);
        return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, advance both models and
    // queue what each DUT must show after the next rising edge.
    task automatic cycle(input bit r, input bit v);
        @(negedge clk);
        rst        = r;
        imem_valid = v;
        dbg_sel    = 2'($urandom_range(0, 3));
        ma = step(ma, 8, r, v, prog[ma.ip]);
        mb = step(mb, 4, r, v, prog[mb.ip]);
        qa.push_back(expect_of(ma, dbg_sel));
        qb.push_back(expect_of(mb, dbg_sel));
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    // Program memory is only rewritten while reset is being applied, so the
    // edge the previous cycle queued still sees the old program.
    task automatic reset2();
        cycle(1'b1, 1'b1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_ip",     a_ip,   e.ip);
                chk("a_addr",   a_addr, e.ip);
                chk("a_z",      a_z,    e.z);
                chk("a_c",      a_c,    e.c);
                chk("a_halted", a_h,    e.h);
                chk("a_dbg",    a_dbg,  e.dbg);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_ip",     b_ip,   e.ip);
                chk("b_addr",   b_addr, e.ip);
                chk("b_z",      b_z,    e.z);
                chk("b_c",      b_c,    e.c);
                chk("b_halted", b_h,    e.h);
                chk("b_dbg",    b_dbg,  e.dbg);
            end
        end
    end

    initial begin : drv
        ma = '0;
        mb = '0;
        clear_prog();

        // Reset held two cycles with valid high
        reset2();
        reset2();

        // LDI r0,5; LDI r1,3; ADD r0,r1; HLT, then sit halted
        reset2();
        prog[0] = ins(1, 0, 0, 5);
        prog[1] = ins(1, 1, 0, 3);
        prog[2] = ins(3, 0, 1, 0);
        prog[3] = ins(15, 0, 0, 0);
        reset2();
        run(13);

        // Carry out of ADDI, then SUB r,r gives zero with no borrow
        reset2();
        clear_prog();
        prog[0] = ins(1, 0, 0, 250);
        prog[1] = ins(11, 0, 0, 10);
        prog[2] = ins(4, 0, 0, 0);
        prog[3] = ins(15, 0, 0, 0);
        reset2();
        run(10);

        // Countdown loop with JNZ
        reset2();
        clear_prog();
        prog[0] = ins(1, 1, 0, 3);
        prog[1] = ins(11, 1, 0, 255);
        prog[2] = ins(10, 0, 0, 1);
        prog[3] = ins(15, 0, 0, 0);
        reset2();
        run(20);

        // Stall: valid dropped for 3 cycles while fetching at ip=1
        reset2();
        clear_prog();
        prog[0] = ins(1, 0, 0, 7);
        prog[1] = ins(1, 1, 0, 9);
        prog[2] = ins(3, 0, 1, 0);
        prog[3] = ins(15, 0, 0, 0);
        reset2();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);   // EXEC ignores valid
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        run(8);

        // Reset landing on the EXEC edge of ADD
        reset2();
        clear_prog();
        prog[0] = ins(1, 0, 0, 1);
        prog[1] = ins(1, 1, 0, 2);
        prog[2] = ins(3, 0, 1, 0);
        prog[3] = ins(15, 0, 0, 0);
        reset2();
        run(5);
        cycle(1'b1, 1'b1);
        run(3);

        // All NOPs: the 4-bit instance wraps ip back to 0
        reset2();
        clear_prog();
        reset2();
        run(40);

        // Random programs, random valid gaps and occasional resets
        for (int p = 0; p < 6; p++) begin
            reset2();
            for (int i = 0; i < 256; i++) begin
                int op, imm;
                op  = int'($urandom_range(0, 15));
                if (op == 15 && $urandom_range(0, 7) != 0) op = 0;
                imm = int'($urandom_range(0, 255));
                if (op >= 8 && op <= 10 && $urandom_range(0, 1) == 1)
                    imm = int'($urandom_range(0, 31));
                prog[i] = ins(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), imm);
            end
            reset2();
            for (int c = 0; c < 150; c++)
                cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        #2;
        chk("queue_drain", 32'(qa.size() + qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
